// File: rtl/clock_gate_ctrl_pkg.sv
// Shared definitions for the clock-gate controller: FSM state encoding,
// default timing parameters and the state-to-output decode.
package clock_gate_ctrl_pkg;

    localparam int DEFAULT_IDLE_CYCLES = 16;
    localparam int DEFAULT_WAKE_CYCLES = 2;
    localparam int DEFAULT_CNT_WIDTH   = 8;

    // Encoding is visible on state_o, so keep the values stable.
    typedef enum logic [2:0] {
        RUN       = 3'd0,
        IDLE      = 3'd1,
        SLEEP_REQ = 3'd2,
        GATED     = 3'd3,
        WAKE      = 3'd4
    } cg_state_e;

    typedef struct packed {
        logic clk_en;
        logic clk_ready;
        logic sleep_req;
    } cg_out_t;

    // Output values held while the FSM sits in a given state. Unknown
    // encodings decode to "clock running" so a corrupted state never stops
    // the clock.
    function automatic cg_out_t cg_outputs(input cg_state_e st);
        cg_out_t o;
        case (st)
            RUN:       o = '{clk_en: 1'b1, clk_ready: 1'b1, sleep_req: 1'b0};
            IDLE:      o = '{clk_en: 1'b1, clk_ready: 1'b1, sleep_req: 1'b0};
            SLEEP_REQ: o = '{clk_en: 1'b1, clk_ready: 1'b1, sleep_req: 1'b1};
            GATED:     o = '{clk_en: 1'b0, clk_ready: 1'b0, sleep_req: 1'b1};
            WAKE:      o = '{clk_en: 1'b1, clk_ready: 1'b0, sleep_req: 1'b0};
            default:   o = '{clk_en: 1'b1, clk_ready: 1'b1, sleep_req: 1'b0};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/clock_gate_ctrl.sv
// Clock-gate controller: watches the gated domain for a run of idle cycles,
// handshakes a sleep request, drops the clock-gate enable once the domain
// acknowledges, and restores the clock on a wake event after a fixed
// settle time. One counter serves both the idle run and the wake settle.
module clock_gate_ctrl
    import clock_gate_ctrl_pkg::*;
#(
    parameter int IDLE_CYCLES = DEFAULT_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEFAULT_WAKE_CYCLES,
    parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       test_en_i,
    input  logic       busy_i,
    input  logic       wake_i,
    output logic       sleep_req_o,
    input  logic       sleep_ack_i,
    output logic       clk_en_o,
    output logic       clk_ready_o,
    output logic [2:0] state_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] IDLE_LAST = CNT_WIDTH'(IDLE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WAKE_LAST = CNT_WIDTH'(WAKE_CYCLES - 1);

    cg_state_e            state_r;
    cg_state_e            state_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [CNT_WIDTH-1:0] cnt_nxt_s;
    cg_out_t              out_r;
    logic                 stay_s;
    logic                 gated_exit_s;

    // Anything that needs the clock keeps it; test mode counts as disabled.
    assign stay_s       = ~en_i | test_en_i | busy_i | wake_i;
    // While gated, busy is meaningless, so only wake/disable/test reopen it.
    assign gated_exit_s = wake_i | ~en_i | test_en_i;

    // Next-state and counter decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            RUN: begin
                if (stay_s) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = CNT_ONE;
                end
            end
            IDLE: begin
                if (stay_s) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == IDLE_LAST) begin
                    state_nxt_s = SLEEP_REQ;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            SLEEP_REQ: begin
                // A late stay condition aborts even if the ack arrives with it.
                if (stay_s) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (sleep_ack_i) begin
                    state_nxt_s = GATED;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = SLEEP_REQ;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            GATED: begin
                if (gated_exit_s) begin
                    state_nxt_s = WAKE;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = GATED;
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            WAKE: begin
                // Settle time is fixed; no input can shorten or extend it.
                if (cnt_r == WAKE_LAST) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    state_nxt_s = WAKE;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = RUN;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // State, counter and output registers; reset reopens the clock at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= RUN;
            cnt_r   <= CNT_ZERO;
            out_r   <= cg_outputs(RUN);
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            out_r   <= cg_outputs(state_nxt_s);
        end
    end

    // Outputs come straight from flops so the gate enable cannot glitch.
    assign clk_en_o    = out_r.clk_en;
    assign clk_ready_o = out_r.clk_ready;
    assign sleep_req_o = out_r.sleep_req;
    assign state_o     = state_r;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed scoreboard bench for clock_gate_ctrl with IDLE_CYCLES=4,
// WAKE_CYCLES=2. Each vector drives inputs on the falling edge and queues
// the hand-computed state/outputs expected after the next rising edge; an
// independent monitor pops and compares after every rising clock or reset.
module tb_clock_gate_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       ce;
        logic       rdy;
        logic       sr;
    } exp_t;

    localparam exp_t E_RUN   = {3'd0, 1'b1, 1'b1, 1'b0};
    localparam exp_t E_IDLE  = {3'd1, 1'b1, 1'b1, 1'b0};
    localparam exp_t E_SREQ  = {3'd2, 1'b1, 1'b1, 1'b1};
    localparam exp_t E_GATED = {3'd3, 1'b0, 1'b0, 1'b1};
    localparam exp_t E_WAKE  = {3'd4, 1'b1, 1'b0, 1'b0};

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       en        = 1'b0;
    logic       test_en   = 1'b0;
    logic       busy      = 1'b0;
    logic       wake      = 1'b0;
    logic       sleep_ack = 1'b0;
    logic       sleep_req;
    logic       clk_en;
    logic       clk_ready;
    logic [2:0] state;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    clock_gate_ctrl #(
        .IDLE_CYCLES(4),
        .WAKE_CYCLES(2),
        .CNT_WIDTH  (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .test_en_i  (test_en),
        .busy_i     (busy),
        .wake_i     (wake),
        .sleep_req_o(sleep_req),
        .sleep_ack_i(sleep_ack),
        .clk_en_o   (clk_en),
        .clk_ready_o(clk_ready),
        .state_o    (state)
    );

    always #5 clk = ~clk;

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(posedge clk or posedge rst) begin
        exp_t  e;
        string nm;
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_vec++;
            if ({state, clk_en, clk_ready, sleep_req} !== e) begin
                n_bad++;
                $display("FAIL %s: got st=%0d clk_en=%b ready=%b req=%b, want st=%0d clk_en=%b ready=%b req=%b",
                         nm, state, clk_en, clk_ready, sleep_req, e.st, e.ce, e.rdy, e.sr);
            end
        end
    end

    task automatic vec(input string nm, input logic r, input logic e, input logic t,
                       input logic b, input logic w, input logic a, input exp_t x);
        @(negedge clk);
        rst       = r;
        en        = e;
        test_en   = t;
        busy      = b;
        wake      = w;
        sleep_ack = a;
        exp_q.push_back(x);
        name_q.push_back(nm);
        @(posedge clk);
    endtask

    initial begin
        // reset held: idle inputs must not move the FSM
        vec("reset_hold",  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);

        // full idle run: request after 4th idle sample, gate 1 cycle after ack
        vec("a_idle1",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("a_idle2",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("a_idle3",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("a_req",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_SREQ);
        vec("a_wait_ack",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_SREQ);
        vec("a_ack",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_GATED);
        vec("g_ign_busy",  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, E_GATED);
        vec("g_hold",      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_GATED);

        // wake pulse: enable next cycle, ready two cycles later
        vec("d_wake",      1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, E_WAKE);
        vec("d_wake_ign",  1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, E_WAKE);
        vec("d_ready",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);

        // busy on 3rd idle sample restarts the count
        vec("b_idle1",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("b_idle2",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("b_busy",      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, E_RUN);
        vec("b_idle3",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("b_idle4",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("b_idle5",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("b_req",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_SREQ);

        // wake and ack together: abort wins, clock never stops
        vec("c_abort",     1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, E_RUN);

        // gate again, then reopen by disabling the feature
        vec("e_idle1",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("e_idle2",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("e_idle3",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("e_req",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_SREQ);
        vec("e_ack",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_GATED);
        vec("e_off_exit",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_WAKE);
        vec("e_wake2",     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_WAKE);
        vec("e_run",       1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
        vec("e_off_stay",  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);

        // test mode with no work: never leaves RUN
        for (int i = 0; i < 6; i++) begin
            vec($sformatf("tm_run%0d", i), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_RUN);
        end

        // gate once more, then reset mid-GATED
        vec("f_idle1",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("f_idle2",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("f_idle3",     1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);
        vec("f_req",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_SREQ);
        vec("f_ack",       1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, E_GATED);

        // asynchronous reset between clock edges
        #3;
        exp_q.push_back(E_RUN);
        name_q.push_back("async_rst");
        rst = 1'b1;

        vec("rst_hold2",   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_RUN);
        vec("post_rst",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, E_IDLE);

        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
